tech_regfile_ctrl: RTL and testbench

TECH_REGFILE_CTRL -- requirements
Module: tech_regfile_ctrl

---
 rtl/tech_regfile_ctrl.sv | 141 ++++++++++++++
 tb/tb_tech_regfile_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tech_regfile_ctrl.sv
// Valid/ready front end for a single-port, 1-cycle-latency, active-low regfile macro.
// Partial writes become a read followed by a merged full-word write; reads return through a 2-deep FWFT FIFO.
module tech_regfile_ctrl #(
    parameter  int BIT_WIDTH  = 128,
    parameter  int WORD_DEPTH = 64,
    localparam int AW         = $clog2(WORD_DEPTH),
    localparam int BYTES      = BIT_WIDTH / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [BYTES-1:0]     req_bm_i,
    input  logic [AW-1:0]        req_addr_i,
    input  logic [BIT_WIDTH-1:0] req_dat_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [BIT_WIDTH-1:0] rsp_dat_o,
    output logic                 mem_en_o,
    output logic                 mem_wen_o,
    output logic [AW-1:0]        mem_addr_o,
    output logic [BIT_WIDTH-1:0] mem_dat_o,
    input  logic [BIT_WIDTH-1:0] mem_dat_i
);

    typedef enum logic {IDLE, MERGE} state_e;

    state_e               state_q, state_d;
    logic                 rd_pend_q, rd_pend_d;
    logic [1:0]           cnt_q, cnt_d;
    logic                 wr_ptr_q, rd_ptr_q;
    logic [BIT_WIDTH-1:0] fifo_q [2];

    logic [AW-1:0]        m_addr_q;
    logic [BIT_WIDTH-1:0] m_dat_q;
    logic [BYTES-1:0]     m_bm_q;
    logic [BIT_WIDTH-1:0] m_mask;
    logic                 capture;

    logic [2:0]           credit;
    logic                 accept, push, pop;
    logic                 full_mask, zero_mask;

    always_comb begin
        m_mask = '0;
        for (int i = 0; i < BYTES; i++) m_mask[8*i +: 8] = {8{m_bm_q[i]}};
    end

    assign credit    = {1'b0, cnt_q} + {2'b00, rd_pend_q};
    assign accept    = req_valid_i && req_ready_o;
    assign full_mask = &req_bm_i;
    assign zero_mask = ~|req_bm_i;

    // Ready is gated by reset so a request held during reset can never reach the macro.
    always_comb begin
        state_d     = state_q;
        rd_pend_d   = 1'b0;
        req_ready_o = 1'b0;
        mem_en_o    = 1'b1;
        mem_wen_o   = 1'b1;
        mem_addr_o  = '0;
        mem_dat_o   = '0;
        capture     = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = rst_n_i && (credit < 3'd2);
                if (accept) begin
                    if (!req_we_i) begin
                        mem_en_o   = 1'b0;
                        mem_addr_o = req_addr_i;
                        rd_pend_d  = 1'b1;
                    end else if (full_mask) begin
                        mem_en_o   = 1'b0;
                        mem_wen_o  = 1'b0;
                        mem_addr_o = req_addr_i;
                        mem_dat_o  = req_dat_i;
                    end else if (!zero_mask) begin
                        // Read-modify-write: this read feeds the merge, not the response FIFO.
                        mem_en_o   = 1'b0;
                        mem_addr_o = req_addr_i;
                        capture    = 1'b1;
                        state_d    = MERGE;
                    end
                end
            end
            MERGE: begin
                mem_en_o   = 1'b0;
                mem_wen_o  = 1'b0;
                mem_addr_o = m_addr_q;
                mem_dat_o  = (mem_dat_i & ~m_mask) | (m_dat_q & m_mask);
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign push        = rd_pend_q;
    assign rsp_valid_o = (cnt_q != 2'd0);
    assign pop         = rsp_valid_o && rsp_ready_i;
    assign rsp_dat_o   = fifo_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            rd_pend_q <= 1'b0;
            cnt_q     <= 2'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            m_addr_q  <= '0;
            m_dat_q   <= '0;
            m_bm_q    <= '0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= rd_pend_d;
            cnt_q     <= cnt_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= mem_dat_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            if (capture) begin
                m_addr_q <= req_addr_i;
                m_dat_q  <= req_dat_i;
                m_bm_q   <= req_bm_i;
            end
        end
    end

endmodule

// File: tb/tb_tech_regfile_ctrl.sv
// Scoreboard bench: a word-array reference model predicts read data at accept time,
// a negedge monitor compares each presented response in order.
module tb_tech_regfile_ctrl;
    localparam int BW    = 128;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int NB    = BW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid_i, req_ready_o, req_we_i;
    logic [NB-1:0] req_bm_i;
    logic [AW-1:0] req_addr_i;
    logic [BW-1:0] req_dat_i;
    logic          rsp_valid_o, rsp_ready_i;
    logic [BW-1:0] rsp_dat_o;
    logic          mem_en_o, mem_wen_o;
    logic [AW-1:0] mem_addr_o;
    logic [BW-1:0] mem_dat_o, mem_dat_i;

    logic [BW-1:0] smem [DEPTH] = '{default: '0};
    logic [BW-1:0] rmem [DEPTH] = '{default: '0};
    logic [BW-1:0] exp_q [$];
    int            rsp_mode = 1;
    int            n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    tech_regfile_ctrl dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_bm_i(req_bm_i), .req_addr_i(req_addr_i), .req_dat_i(req_dat_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
        .mem_en_o(mem_en_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
        .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i)
    );

    // Regfile macro: read data valid one cycle after the read, garbage otherwise.
    always @(posedge clk) begin
        if (!mem_en_o && !mem_wen_o) smem[mem_addr_o] <= mem_dat_o;
        if (!mem_en_o && mem_wen_o) mem_dat_i <= smem[mem_addr_o];
        else mem_dat_i <= {$urandom, $urandom, $urandom, $urandom};
    end

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: word array updated in request order, byte enables applied directly.
    task automatic model_accept(input logic we, input logic [NB-1:0] bm,
                                input logic [AW-1:0] addr, input logic [BW-1:0] dat);
        if (!we) exp_q.push_back(rmem[addr]);
        else for (int i = 0; i < NB; i++) if (bm[i]) rmem[addr][8*i +: 8] = dat[8*i +: 8];
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
            else chk("rsp_data", rsp_dat_o, exp_q.pop_front());
        end
    end

    initial begin
        rsp_ready_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rsp_mode)
                0:       rsp_ready_i = 1'b0;
                1:       rsp_ready_i = 1'b1;
                default: rsp_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send(input logic we, input logic [NB-1:0] bm, input logic [AW-1:0] addr,
                        input logic [BW-1:0] dat, input bit upd, output int waits);
        req_valid_i = 1'b1; req_we_i = we; req_bm_i = bm; req_addr_i = addr; req_dat_i = dat;
        waits = 0;
        while (1) begin
            @(negedge clk);
            if (req_ready_o) break;
            waits++;
            if (waits >= 200) break;
        end
        if (waits >= 200) begin
            n_chk++;
            $display("FAIL accept_timeout: no accept within %0d cycles, required accept", waits);
        end else if (upd) model_accept(we, bm, addr, dat);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
    endtask

    task automatic drain();
        int cyc = 0;
        rsp_mode = 1;
        while ((exp_q.size() != 0 || rsp_valid_o) && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        chk("drain_pending", exp_q.size(), 0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        int w, errs;
        logic [BW-1:0] d, v;
        logic [NB-1:0] bm;
        logic [AW-1:0] a;
        rst_n = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_bm_i = '0;
        req_addr_i = '0; req_dat_i = '0;

        // Reset values, before any clock edge and again after edges under reset.
        #2;
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_mem_en", mem_en_o, 1);
        chk("rst_mem_wen", mem_wen_o, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_dat", mem_dat_o, 0);
        chk("rst_rsp_dat", rsp_dat_o, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", req_ready_o, 1);
        @(posedge clk); #1;

        // Full write then read of address 5, with response timing.
        d = {96'h0123_4567_89AB_CDEF_0F0F_0F0F, 32'h0000_A5A5};
        send(1'b1, '1, 6'd5, d, 1'b1, w);
        send(1'b0, '0, 6'd5, '0, 1'b1, w);
        @(negedge clk);
        chk("rd_lat_not_early", rsp_valid_o, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rd_lat_valid", rsp_valid_o, 1);
        @(posedge clk); #1;
        drain();

        // Partial write merge on address 3.
        send(1'b1, '1, 6'd3, {96'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF, 32'h1122_3344}, 1'b1, w);
        send(1'b1, 16'h0001, 6'd3, {96'h0, 32'h0000_00FF}, 1'b1, w);
        @(negedge clk);
        chk("merge_ready_low", req_ready_o, 0);
        chk("merge_wr_en", {mem_en_o, mem_wen_o}, 2'b00);
        chk("merge_wr_addr", mem_addr_o, 3);
        chk("merge_wr_dat", mem_dat_o, {96'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF, 32'h1122_33FF});
        @(posedge clk); #1;
        send(1'b0, '0, 6'd3, '0, 1'b1, w);
        chk("post_merge_no_wait", w, 0);
        drain();

        // Throughput: full writes back to back, partial write costs one extra cycle.
        for (int i = 0; i < 4; i++) begin
            send(1'b1, '1, 6'(16 + i), {4{$urandom}}, 1'b1, w);
            if (i > 0) chk("full_wr_b2b", w, 0);
        end
        send(1'b1, 16'h0F0F, 6'd20, {4{$urandom}}, 1'b1, w);
        send(1'b1, '1, 6'd21, {4{$urandom}}, 1'b1, w);
        chk("partial_wr_2cyc", w, 1);

        // Credit limit with the response side stalled.
        drain();
        rsp_mode = 0;
        @(posedge clk); #1;
        send(1'b0, '0, 6'd16, '0, 1'b1, w);
        send(1'b0, '0, 6'd17, '0, 1'b1, w);
        chk("credit_2nd_accept", w, 0);
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 6'd18;
        errs = 0;
        repeat (4) begin
            @(negedge clk);
            if (req_ready_o) errs++;
            @(posedge clk); #1;
        end
        chk("credit_block", errs, 0);
        chk("credit_fifo_full", rsp_valid_o, 1);
        rsp_mode = 1;
        send(1'b0, '0, 6'd18, '0, 1'b1, w);
        drain();

        // Zero-mask write: consumed in one cycle, no memory access.
        send(1'b1, '1, 6'd7, {4{32'h5A5A_1234}}, 1'b1, w);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_bm_i = '0; req_addr_i = 6'd7;
        req_dat_i = {4{$urandom}};
        @(negedge clk);
        chk("bm0_ready", req_ready_o, 1);
        chk("bm0_no_access", mem_en_o, 1);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(negedge clk);
        chk("bm0_idle_after", {req_ready_o, mem_en_o}, 2'b11);
        @(posedge clk); #1;
        chk("bm0_mem_unchanged", smem[7], rmem[7]);

        // Reset in the merge cycle aborts the merge write.
        v = {4{32'hCAFE_F00D}};
        send(1'b1, '1, 6'd9, v, 1'b1, w);
        send(1'b1, 16'h00F0, 6'd9, {4{$urandom}}, 1'b0, w);
        #1; rst_n = 1'b0;
        #1;
        chk("rst_merge_en", mem_en_o, 1);
        chk("rst_merge_rsp_valid", rsp_valid_o, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_merge_ready", req_ready_o, 1);
        chk("rst_merge_word", smem[9], rmem[9]);
        @(posedge clk); #1;
        send(1'b0, '0, 6'd9, '0, 1'b1, w);
        drain();

        // Randomized traffic over a small address window to force hazards.
        rsp_mode = 2;
        for (int n = 0; n < 300; n++) begin
            a = 6'($urandom_range(0, 7));
            d = {$urandom, $urandom, $urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       bm = '1;
                1:       bm = '0;
                default: bm = 16'($urandom);
            endcase
            send(1'($urandom_range(0, 1)), bm, a, d, 1'b1, w);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        drain();

        errs = 0;
        for (int i = 0; i < DEPTH; i++) if (smem[i] !== rmem[i]) errs++;
        chk("mem_final", errs, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end
endmodule
